audply_controller: RTL and testbench
====================================

Name: audply_controller

Overview:
- Bus-attached mono audio playback block; drives a 24-bit, MSB-first, left-aligned I2S-style DAC link as link master (generates sck, ws and sd).
- Software pushes samples through a write-only data register into a small FIFO.
- The serializer pops one sample per frame.
- Sits on the peripheral bus beside the audio acquisition block and uses the same frame timing.

Parameters:
- PRIMARY_DIV, 26, clk cycles per link tick (trigger).
- FIFO_DEPTH, 4, sample FIFO entries; power of 2, minimum 2.
- VA_WIDTH, 3, address port width.
- CH_DUP, 1, 1: HIGH (right) half repeats the sample; 0: HIGH half drives zeros.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- addr  in  VA_WIDTH  byte address
- w_rb  in  1  1=write, 0=read
- acc  in  `BUS_ACC_WIDTH  access size
- wdata  in  `BUS_WIDTH  write data
- req  in  1  request strobe
- rdata  out  `BUS_WIDTH  read data
- resp  out  1  response, one cycle
- fault  out  1  combinational, req & invalid
- sck  out  1  bit clock
- ws  out  1  word select, low = left/sampled half
- sd  out  1  serial data

Behaviour:
- Registers:
  - DR at address 0: write-only, 4B. wdata[23:0] is pushed to the FIFO.
  - SR at address 4: read-only, 4B. Bit 31 = underrun (sticky), bit 30 = overflow (sticky), bits [clog2(FIFO_DEPTH):0] = FIFO level, other bits 0.
- Invalid access, any one of: addr not 0 or 4, acc != `BUS_ACC_4B, read of DR, write of SR. An invalid access has no side effects and gets no resp.
- resp: registered, asserted one cycle after a valid req. rdata is valid with resp and holds its value otherwise. Reset: resp=0, rdata=0.
- Push on a full FIFO: data dropped, overflow set.
- FIFO pop and push in the same cycle: both take effect, level unchanged. A push on a full FIFO in the pop cycle is accepted.
- SR read clears both sticky flags in the accept cycle. A flag-set event in the same cycle wins: the flag stays 1.
- Divider: prim_div_cnt counts 0..PRIMARY_DIV-1 and wraps. trigger = (cnt==0). State and count advance only on trigger.
- State machine, count 0..63 (6 bits used):
  - IDLE -> LOW at count 63, for the first 64 ticks after reset.
  - LOW -> HIGH at count 63.
  - HIGH -> LOW at count 63.
  - count resets to 0 on every state change.
- Link outputs:
  - sck = IDLE | count[0].
  - ws = IDLE | HIGH.
  - sd = 0 in IDLE.
- Frame load: on the trigger that enters LOW (from IDLE or HIGH), the hold register loads the FIFO head and the FIFO pops. If the FIFO is empty, the hold register loads 0, underrun is set, and nothing pops.
- Serialization:
  - During LOW, counts 2k+2 and 2k+3 (k=0..23) drive sd = hold[23-k].
  - Counts 0, 1 and 50..63 drive sd = 0.
  - HIGH uses the same timing with hold if CH_DUP=1, otherwise sd = 0.
  - sd changes only on trigger cycles with an even count (sck falling), so the receiver samples on sck rising.
- All link outputs are registered or decoded from registered state; no glitch on sd.
- Reset mid-frame: state=IDLE, count=0, FIFO emptied (level 0), hold=0, flags=0. sck and ws return high.

Test Plan:
- Reset, no writes, run 3 frames -> sck/ws high for 64 ticks. Then ws low 64 ticks / high 64 ticks. sd=0 throughout. SR reads 0x80000000 (underrun) after the first LOW entry. A second SR read returns 0x00000000 if issued before the next LOW entry.
- Write DR=0x00A5F00F before the first LOW -> sd bits in LOW at counts 2..49 equal 1010_0101_1111_0000_0000_1111 MSB first. With CH_DUP=1 the same bits repeat in HIGH. SR level goes 1 -> 0 at LOW entry.
- Write 5 samples back-to-back in IDLE (FIFO_DEPTH=4) -> 5th dropped, SR=0x40000004. Frames play samples 1-4 in order, then underrun sets on frame 5.
- Invalid accesses: read addr 0, write addr 4, addr 2, acc=2B -> fault=1 in the req cycle, resp stays 0, FIFO/flags unchanged.
- Push while full on the exact trigger cycle of LOW entry -> push accepted, level stays 4, overflow not set.
- Assert rstn low mid-LOW at count 20 -> next cycle sck=1, ws=1, sd=0, SR=0. Playback restarts with 64 IDLE ticks.

Source files
------------

// File: rtl/audply_controller.sv
// Mono playback block: software fills a small sample FIFO over the peripheral bus,
// and a framer/serializer drives a 24-bit MSB-first left-aligned DAC link as master.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module audply_controller #(
   parameter int PRIMARY_DIV = 26,
   parameter int FIFO_DEPTH  = 4,
   parameter int VA_WIDTH    = 3,
   parameter bit CH_DUP      = 1'b1
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [VA_WIDTH-1:0]       addr,
   input  logic                      w_rb,
   input  logic [`BUS_ACC_WIDTH-1:0] acc,
   input  logic [`BUS_WIDTH-1:0]     wdata,
   input  logic                      req,
   output logic [`BUS_WIDTH-1:0]     rdata,
   output logic                      resp,
   output logic                      fault,
   output logic                      sck,
   output logic                      ws,
   output logic                      sd
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int DW = (PRIMARY_DIV > 1) ? $clog2(PRIMARY_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(PRIMARY_DIV - 1);
   localparam logic [PW:0]   FULL_LVL = (PW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOW = 2'd1, S_HIGH = 2'd2} state_t;

   logic [DW-1:0]           r_div;
   state_t                  r_state, w_state_nxt;
   logic [5:0]              r_count, w_count_nxt;
   logic [23:0]             r_hold, w_hold_nxt;
   logic [23:0]             r_mem [FIFO_DEPTH];
   logic [PW:0]             r_wp, r_rp;
   logic                    r_und, r_ovf, r_resp, r_sck, r_ws, r_sd;
   logic [`BUS_WIDTH-1:0]   r_rdata;

   logic w_trig, w_load, w_ok, w_valid, w_push_req, w_push, w_pop, w_sr_rd;
   logic w_empty, w_full, w_und_set, w_ovf_set, w_unused;
   logic [PW:0]             w_level;
   logic [`BUS_WIDTH-1:0]   w_sr;

   // Serial data for a given link position: MSB of hold at counts 2/3, LSB at 48/49.
   function automatic logic sd_bit(input state_t st, input logic [5:0] cnt, input logic [23:0] hold);
      logic [5:0] off;
      logic       active;
      off    = cnt - 6'd2;
      active = (st == S_LOW) || ((st == S_HIGH) && CH_DUP);
      if (active && (cnt >= 6'd2) && (cnt <= 6'd49)) begin
         return hold[5'd23 - off[5:1]];
      end else begin
         return 1'b0;
      end
   endfunction

   assign w_trig     = (r_div == {DW{1'b0}});
   assign w_load     = w_trig && (r_count == 6'd63) && (r_state != S_LOW);
   assign w_level    = r_wp - r_rp;
   assign w_empty    = (w_level == {(PW + 1){1'b0}});
   assign w_full     = (w_level == FULL_LVL);
   assign w_ok       = (acc == `BUS_ACC_4B) &&
                       (((addr == {VA_WIDTH{1'b0}}) && w_rb) || ((addr == VA_WIDTH'(3'd4)) && !w_rb));
   assign w_valid    = req && w_ok;
   assign fault      = req && !w_ok;
   assign w_push_req = w_valid && w_rb;
   assign w_sr_rd    = w_valid && !w_rb;
   assign w_pop      = w_load && !w_empty;
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_ovf_set  = w_push_req && w_full && !w_pop;
   assign w_und_set  = w_load && w_empty;
   assign w_sr       = {r_und, r_ovf, {(`BUS_WIDTH - PW - 3){1'b0}}, w_level};
   assign w_unused   = ^wdata[`BUS_WIDTH-1:24];

   // Frame sequencer next state; state and count only move on a link tick.
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      if (w_trig) begin
         if (r_count == 6'd63) begin
            w_count_nxt = 6'd0;
            case (r_state)
               S_IDLE:  w_state_nxt = S_LOW;
               S_LOW:   w_state_nxt = S_HIGH;
               S_HIGH:  w_state_nxt = S_LOW;
               default: w_state_nxt = S_IDLE;
            endcase
         end else begin
            w_count_nxt = r_count + 6'd1;
         end
      end else begin
         w_state_nxt = r_state;
         w_count_nxt = r_count;
      end
   end

   // Hold register takes the FIFO head (or silence on underrun) when a left half starts.
   always_comb begin
      w_hold_nxt = r_hold;
      if (w_load) begin
         w_hold_nxt = w_empty ? 24'd0 : r_mem[r_rp[PW-1:0]];
      end else begin
         w_hold_nxt = r_hold;
      end
   end

   // Link outputs are computed from the next sequencer state so they line up with it.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_div   <= {DW{1'b0}};
         r_state <= S_IDLE;
         r_count <= 6'd0;
         r_hold  <= 24'd0;
         r_sck   <= 1'b1;
         r_ws    <= 1'b1;
         r_sd    <= 1'b0;
      end else begin
         r_div   <= (r_div == DIV_LAST) ? {DW{1'b0}} : r_div + DW'(1'b1);
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_hold  <= w_hold_nxt;
         r_sck   <= (w_state_nxt == S_IDLE) || w_count_nxt[0];
         r_ws    <= (w_state_nxt != S_LOW);
         r_sd    <= sd_bit(w_state_nxt, w_count_nxt, w_hold_nxt);
      end
   end

   // FIFO pointers, sticky flags and bus response; a flag set beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wp    <= {(PW + 1){1'b0}};
         r_rp    <= {(PW + 1){1'b0}};
         r_und   <= 1'b0;
         r_ovf   <= 1'b0;
         r_resp  <= 1'b0;
         r_rdata <= {`BUS_WIDTH{1'b0}};
      end else begin
         if (w_push) r_wp <= r_wp + (PW + 1)'(1'b1);
         if (w_pop)  r_rp <= r_rp + (PW + 1)'(1'b1);
         r_und  <= w_und_set || (r_und && !w_sr_rd);
         r_ovf  <= w_ovf_set || (r_ovf && !w_sr_rd);
         r_resp <= w_valid;
         if (w_sr_rd) r_rdata <= w_sr;
      end
   end

   // Sample storage; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp[PW-1:0]] <= wdata[23:0];
   end

   assign rdata = r_rdata;
   assign resp  = r_resp;
   assign sck   = r_sck;
   assign ws    = r_ws;
   assign sd    = r_sd;
endmodule

// File: tb/tb_audply_controller.sv
// Self-checking bench for audply_controller: a frame-position model derived from the
// tick count, plus a queue-based FIFO model, compared against the DUT every cycle.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module tb_audply_controller;
   localparam int DIV   = 26;
   localparam int DEPTH = 4;
   localparam bit DUP   = 1'b1;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [2:0]  addr = 3'd0;
   logic        w_rb = 1'b0;
   logic [1:0]  acc = 2'd2;
   logic [31:0] wdata = 32'd0;
   logic        req = 1'b0;
   logic [31:0] rdata;
   logic        resp, fault, sck, ws, sd;

   always #5 clk = ~clk;

   audply_controller #(.PRIMARY_DIV(DIV), .FIFO_DEPTH(DEPTH), .VA_WIDTH(3), .CH_DUP(DUP)) dut (
      .clk(clk), .rstn(rstn), .addr(addr), .w_rb(w_rb), .acc(acc), .wdata(wdata),
      .req(req), .rdata(rdata), .resp(resp), .fault(fault), .sck(sck), .ws(ws), .sd(sd)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model state
   logic [23:0] q[$];
   int          m_cyc, m_ticks;
   logic [23:0] m_hold;
   logic        m_und, m_ovf, m_resp, m_rd;
   logic [31:0] m_rdata;
   logic [23:0] cap_low, cap_high;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit acc_ok(input logic [2:0] a, input logic wr, input logic [1:0] ac);
      return (ac == `BUS_ACC_4B) && (((a == 3'd0) && wr) || ((a == 3'd4) && !wr));
   endfunction

   // Link position after t ticks: 64 idle ticks, then frames of 64 low + 64 high ticks.
   task automatic phase(input int t, output int st, output int c);
      int w;
      if (t < 64) begin
         st = 0;
         c  = t;
      end else begin
         w  = (t - 64) % 128;
         st = (w < 64) ? 1 : 2;
         c  = w % 64;
      end
   endtask

   task automatic step();
      logic        ok, load, us, os;
      logic [31:0] sr;
      int          st, c, idx;
      logic        e_sd;
      ok = req && acc_ok(addr, w_rb, acc);
      #1;
      chk("fault", fault, req && !acc_ok(addr, w_rb, acc));
      @(posedge clk);
      if (!rstn) begin
         m_cyc = 0; m_ticks = 0; q.delete(); m_hold = 24'd0;
         m_und = 0; m_ovf = 0; m_resp = 0; m_rd = 0; m_rdata = 32'd0;
      end else begin
         load = 0; us = 0; os = 0;
         if (m_cyc % DIV == 0) begin
            m_ticks++;
            load = (m_ticks >= 64) && ((m_ticks - 64) % 128 == 0);
         end
         m_cyc++;
         sr = {m_und, m_ovf, 27'd0, 3'(q.size())};
         if (load) begin
            if (q.size() == 0) begin m_hold = 24'd0; us = 1; end
            else m_hold = q.pop_front();
         end
         if (ok && w_rb) begin
            if (q.size() < DEPTH) q.push_back(wdata[23:0]);
            else os = 1;
         end
         if (ok && !w_rb) begin m_und = 0; m_ovf = 0; m_rdata = sr; end
         m_und  = m_und | us;
         m_ovf  = m_ovf | os;
         m_resp = ok;
         m_rd   = ok && !w_rb;
      end
      #1;
      phase(m_ticks, st, c);
      e_sd = 1'b0;
      if (((st == 1) || (st == 2 && DUP)) && c >= 2 && c <= 49) e_sd = m_hold[23 - (c - 2) / 2];
      chk("sck", sck, (st == 0) || (c % 2 == 1));
      chk("ws", ws, st != 1);
      chk("sd", sd, e_sd);
      chk("resp", resp, m_resp);
      if (!m_resp || m_rd) chk("rdata", rdata, m_rdata);
      if (st != 0 && c >= 2 && c <= 49) begin
         idx = 23 - (c - 2) / 2;
         if (st == 1) cap_low[idx] = sd;
         else cap_high[idx] = sd;
      end
   endtask

   task automatic bus(input logic [2:0] a, input logic wr, input logic [1:0] ac, input logic [31:0] d);
      addr = a; w_rb = wr; acc = ac; wdata = d; req = 1'b1;
      step();
      req = 1'b0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      step();
      step();
      rstn = 1'b1;
   endtask

   task automatic run_to_tick(input int t);
      int guard = 0;
      while (m_ticks < t && guard < 40000) begin
         step();
         guard++;
      end
      if (m_ticks < t) chk("tick_budget", m_ticks, t);
   endtask

   logic [23:0] samp[5];

   initial begin
      samp = '{24'h123456, 24'h654321, 24'hABCDEF, 24'h0F0F0F, 24'h000000};

      // no writes: underrun on first left half, flags clear on read
      do_reset();
      run_to_tick(64);
      bus(3'd4, 1'b0, 2'd2, 32'd0);
      chk("sr_underrun", rdata, 32'h80000000);
      bus(3'd4, 1'b0, 2'd2, 32'd0);
      chk("sr_cleared", rdata, 32'h00000000);
      run_to_tick(320);

      // single sample, invalid accesses have no effect
      do_reset();
      bus(3'd0, 1'b1, 2'd2, 32'h00A5F00F);
      bus(3'd0, 1'b0, 2'd2, 32'h0);
      bus(3'd4, 1'b1, 2'd2, 32'h11111111);
      bus(3'd2, 1'b1, 2'd2, 32'h22222222);
      bus(3'd0, 1'b1, 2'd1, 32'h33333333);
      bus(3'd4, 1'b0, 2'd2, 32'd0);
      chk("sr_level1", rdata, 32'h00000001);
      run_to_tick(64);
      bus(3'd4, 1'b0, 2'd2, 32'd0);
      chk("sr_level0", rdata, 32'h00000000);
      run_to_tick(128);
      chk("low_bits", cap_low, 24'hA5F00F);
      run_to_tick(192);
      chk("high_bits", cap_high, 24'hA5F00F);

      // overflow on 5th write, four frames in order, then underrun
      do_reset();
      for (int i = 0; i < 4; i++) bus(3'd0, 1'b1, 2'd2, {8'd0, samp[i]});
      bus(3'd0, 1'b1, 2'd2, 32'h00DEAD00);
      bus(3'd4, 1'b0, 2'd2, 32'd0);
      chk("sr_overflow", rdata, 32'h40000004);
      for (int f = 0; f < 5; f++) begin
         run_to_tick(128 + 128 * f);
         chk("frame_sample", cap_low, samp[f]);
      end
      bus(3'd4, 1'b0, 2'd2, 32'd0);
      chk("sr_frame5_underrun", rdata, 32'h80000000);

      // push into a full FIFO on the exact left-half entry edge
      do_reset();
      for (int i = 0; i < 4; i++) bus(3'd0, 1'b1, 2'd2, {8'd0, samp[i]});
      begin
         int guard = 0;
         while (!((m_cyc % DIV) == 0 && m_ticks == 63) && guard < 5000) begin
            step();
            guard++;
         end
      end
      bus(3'd0, 1'b1, 2'd2, 32'h00777777);
      bus(3'd4, 1'b0, 2'd2, 32'd0);
      chk("sr_full_pop_push", rdata, 32'h00000004);

      // reset in the middle of a left half
      do_reset();
      bus(3'd0, 1'b1, 2'd2, 32'h00FFFFFF);
      run_to_tick(84);
      chk("mid_low_sd", sd, 1'b1);
      rstn = 1'b0;
      step();
      chk("rst_sck", sck, 1'b1);
      chk("rst_ws", ws, 1'b1);
      chk("rst_sd", sd, 1'b0);
      rstn = 1'b1;
      bus(3'd4, 1'b0, 2'd2, 32'd0);
      chk("rst_sr", rdata, 32'h00000000);
      run_to_tick(63);
      chk("restart_idle_ws", ws, 1'b1);
      run_to_tick(64);
      chk("restart_low_ws", ws, 1'b0);

      // randomized bus traffic: busy phase then sparse phase
      do_reset();
      for (int i = 0; i < 14000; i++) begin
         if ($urandom_range(0, (i < 6000) ? 29 : 699) == 0) begin
            logic [2:0] ra;
            logic [1:0] rc;
            case ($urandom_range(0, 3))
               0: ra = 3'd0;
               1: ra = 3'd4;
               default: ra = 3'($urandom_range(0, 7));
            endcase
            rc = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
            bus(ra, 1'($urandom_range(0, 1)), rc, $urandom);
         end else begin
            step();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
